fetch_queue: RTL and testbench

- Small instruction buffer between instruction fetch and instruction decode.
- Holds {pc, instruction} pairs produced by fetch and presents them in order to decode through a valid/ready handshake.
- Absorbs decode stalls; discards all buffered entries on a taken branch (flush).

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// master drives the fetch side and consumes the decode side; slave is the queue.
interface fetch_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_instruction;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_instruction;

    modport master (
        output in_valid, in_pc, in_instruction, out_ready,
        input  in_ready, out_valid, out_pc, out_instruction
    );

    modport slave (
        input  in_valid, in_pc, in_instruction, out_ready,
        output in_ready, out_valid, out_pc, out_instruction
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instruction} buffer between fetch and decode, flushed on taken branch.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency path when the queue is empty.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    fetch_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q  [DEPTH];
    logic [DATA_WIDTH-1:0] ins_q [DEPTH];

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic empty, full, byp;
    logic push, pop, wr_en, rd_en;

    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == FULL);
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = empty && !flush && bus.in_valid;
`else
        byp = 1'b0;
`endif
        bus.in_ready        = !full && !flush;
        bus.out_valid       = (!empty && !flush) || byp;
        bus.out_pc          = '0;
        bus.out_instruction = '0;
        if (byp) begin
            bus.out_pc          = bus.in_pc;
            bus.out_instruction = bus.in_instruction;
        end else if (bus.out_valid) begin
            bus.out_pc          = pc_q[rd_q];
            bus.out_instruction = ins_q[rd_q];
        end

        push = bus.in_valid && bus.in_ready;
        pop  = bus.out_valid && bus.out_ready;
        // A bypassed entry taken by decode never touches storage
        wr_en = push && !(byp && bus.out_ready);
        rd_en = pop && !byp;

        wr_d  = wr_en ? wr_q + PW'(1) : wr_q;
        rd_d  = rd_en ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q;
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_q[wr_q]  <= bus.in_pc;
            ins_q[wr_q] <= bus.in_instruction;
        end
    end

    assign count = cnt_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model.
// Literal expectations in the directed part pin the model itself.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk;
    logic reset;
    logic flush;
    logic [$clog2(DEPTH):0] count;

    fetch_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    fetch_queue #(
        .DEPTH(DEPTH),
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bus),
        .count(count)
    );

    int n_checks = 0;
    int n_pass = 0;
    bit started = 0;
    ent_t mq[$];
    logic [31:0] log_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0F00;
    endfunction

    // Reference: a plain FIFO of entries, updated at each edge
    always @(posedge clk) begin : model
        bit do_pop, do_push;
        if (reset || flush) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() > 0) && bus.out_ready;
            do_push = bus.in_valid && (mq.size() < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
            if (mq.size() == 0 && bus.in_valid && bus.out_ready) do_push = 0;
`endif
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{bus.in_pc, bus.in_instruction});
        end
    end

    always @(negedge clk) begin : compare
        logic        ev;
        logic [31:0] epc, eins;
        bit          bp;
        if (started) begin
            bp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
            bp = (mq.size() == 0) && !flush && bus.in_valid;
`endif
            ev   = ((mq.size() > 0) && !flush) || bp;
            epc  = '0;
            eins = '0;
            if (bp) begin
                epc  = bus.in_pc;
                eins = bus.in_instruction;
            end else if (ev) begin
                epc  = mq[0].pc;
                eins = mq[0].ins;
            end
            chk("count", count, mq.size());
            chk("in_ready", bus.in_ready, (mq.size() < DEPTH) && !flush);
            chk("out_valid", bus.out_valid, ev);
            chk("out_pc", bus.out_pc, epc);
            chk("out_instruction", bus.out_instruction, eins);
            if (bus.out_valid && bus.out_ready && !reset)
                log_q.push_back(bus.out_pc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] pc);
        bus.in_valid       = v;
        bus.in_pc          = pc;
        bus.in_instruction = ins_of(pc);
    endtask

    task automatic drain();
        put(1'b0, 32'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (count == 0) break;
            cyc();
        end
        chk("drain_count", count, 0);
    endtask

    task automatic chk_log(input string name, input logic [31:0] exp[$]);
        chk({name, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk(name, log_q[i], exp[i]);
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        bus.out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            put(1'b1, base + 32'(4 * i));
            cyc();
        end
        put(1'b0, 32'h0);
    endtask

    initial begin : stim
        logic [31:0] exp[$];
        bit acc;
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        put(1'b0, 32'h0);
        cyc();
        cyc();
        reset = 1'b0;
        started = 1;

        // 1: two entries through with decode always ready
        bus.out_ready = 1'b1;
        put(1'b1, 32'h0000_0000);
        bus.in_instruction = 32'h1111_1111;
        @(negedge clk);
        chk("t1_reset_count", count, 0);
        chk("t1_reset_in_ready", bus.in_ready, 1);
`ifndef FETCH_QUEUE_BYPASS_EN
        chk("t1_empty_valid", bus.out_valid, 0);
`endif
        cyc();
        put(1'b1, 32'h0000_0004);
        bus.in_instruction = 32'h2222_2222;
`ifndef FETCH_QUEUE_BYPASS_EN
        @(negedge clk);
        chk("t1_first_pc", bus.out_pc, 32'h0);
        chk("t1_first_ins", bus.out_instruction, 32'h1111_1111);
`endif
        cyc();
        put(1'b0, 32'h0);
`ifndef FETCH_QUEUE_BYPASS_EN
        @(negedge clk);
        chk("t1_second_pc", bus.out_pc, 32'h4);
        chk("t1_second_ins", bus.out_instruction, 32'h2222_2222);
`endif
        cyc();
        chk("t1_final_count", count, 0);

        // 2: fill to full, hold a fifth entry, then drain
        log_q.delete();
        fill(4, 32'h0);
        put(1'b1, 32'h10);
        @(negedge clk);
        chk("t2_full_count", count, 4);
        chk("t2_full_in_ready", bus.in_ready, 0);
        chk("t2_head_pc", bus.out_pc, 32'h0);
        cyc();
        chk("t2_held_count", count, 4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = bus.in_ready && bus.in_valid;
            cyc();
            if (acc) put(1'b0, 32'h0);
            if (count == 0 && !bus.in_valid) break;
        end
        exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        chk_log("t2_order", exp);

        // 3: steady push+pop at count 2
        log_q.delete();
        fill(2, 32'h100);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 32'h108 + 32'(4 * i));
            cyc();
            chk("t3_count_steady", count, 2);
        end
        drain();
        exp = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        chk_log("t3_order", exp);

        // 4: flush with three buffered and one in flight
        log_q.delete();
        fill(3, 32'h200);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        put(1'b1, 32'h20C);
        @(negedge clk);
        chk("t4_flush_in_ready", bus.in_ready, 0);
        chk("t4_flush_valid", bus.out_valid, 0);
        cyc();
        flush = 1'b0;
        put(1'b0, 32'h0);
        @(negedge clk);
        chk("t4_post_count", count, 0);
        chk("t4_post_valid", bus.out_valid, 0);
        cyc();
        cyc();
        chk("t4_nothing_out", log_q.size(), 0);

        // 5: ten entries streamed, pointers wrap
        log_q.delete();
        bus.out_ready = 1'b1;
        exp.delete();
        for (int i = 0; i < 10; i++) begin
            put(1'b1, 32'(4 * i));
            exp.push_back(32'(4 * i));
            cyc();
        end
        drain();
        chk_log("t5_order", exp);

        // 6: reset mid-stream
        fill(3, 32'h300);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        put(1'b1, 32'h30C);
        cyc();
        reset = 1'b0;
        put(1'b0, 32'h0);
        @(negedge clk);
        chk("t6_count", count, 0);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_pc", bus.out_pc, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
        cyc();
        put(1'b1, 32'h40);
        @(negedge clk);
        chk("t6_byp_valid", bus.out_valid, 1);
        chk("t6_byp_pc", bus.out_pc, 32'h40);
        cyc();
        put(1'b0, 32'h0);
        chk("t6_byp_count", count, 0);
`endif
        cyc();

        // Randomized traffic with varying pressure
        for (int blk = 0; blk < 10; blk++) begin
            int rdy_bias;
            rdy_bias = int'($urandom_range(1, 9));
            for (int i = 0; i < 200; i++) begin
                put($urandom_range(0, 3) != 0, $urandom);
                bus.in_instruction = $urandom;
                bus.out_ready = $urandom_range(0, 9) < rdy_bias;
                flush = $urandom_range(0, 24) == 0;
                reset = $urandom_range(0, 99) == 0;
                cyc();
            end
        end
        reset = 1'b0;
        flush = 1'b0;
        drain();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
